// File: rtl/spi_arb_pkg.sv
// Shared state encoding, default widths and helpers for the SPI request arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_REQ        = 2;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr.sv
// Round-robin grant: first requester at or after the pointer wins, one-hot result.
module spi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_any
);

  int unsigned w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between NUM_REQ requesters, one transaction at a time.
// Optional watchdog enabled by defining SPI_REQ_ARBITER_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_rd_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_error,
  output logic                             spi_enable,
  output logic                             spi_rd_we,
  output logic [ADDRESS_WIDTH-1:0]         spi_address,
  output logic [DATA_WIDTH-1:0]            spi_data,
  input  logic                             spi_busy,
  input  logic [DATA_WIDTH-1:0]            spi_data_read,
  input  logic                             spi_data_read_valid
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [PTR_W-1:0]           r_ptr;
  logic [NUM_REQ-1:0]         r_grant;
  logic                       r_rd_we;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic [NUM_REQ-1:0]         w_grant;
  logic [PTR_W-1:0]           w_grant_idx;
  logic                       w_any;
  logic                       w_accept;
  logic                       w_timeout;
  logic                       w_error;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;

`ifdef SPI_REQ_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  // Fires in the TIMEOUT_CYCLES-th waiting cycle so RESPOND follows immediately.
  assign w_timeout = (r_state == WAIT_BUSY || r_state == WAIT_DONE) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_error   = r_error;
`else
  assign w_timeout = 1'b0;
  assign w_error   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:      if (w_any) w_next_state = LAUNCH;
      LAUNCH:    w_next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (w_timeout)     w_next_state = RESPOND;
        else if (spi_busy) w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_timeout || !spi_busy) w_next_state = RESPOND;
      end
      RESPOND:   w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_data   = '0;
    rsp_error  = 1'b0;
    spi_enable = 1'b0;
    case (r_state)
      IDLE:    req_ready  = w_grant;
      LAUNCH:  spi_enable = 1'b1;
      RESPOND: begin
        rsp_valid = r_grant;
        rsp_error = w_error;
        if (r_rd_we && !w_error) rsp_data = r_rdata;
      end
      default: ;
    endcase
  end

  assign spi_rd_we   = r_rd_we;
  assign spi_address = r_addr;
  assign spi_data    = r_wdata;

  // Read data is kept across transactions so a read without a strobe returns the last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_rd_we <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant;
        r_rd_we <= req_rd_we[w_grant_idx];
        r_addr  <= req_address[w_grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        r_wdata <= req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
        r_ptr   <= (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
      end
      if (r_state == WAIT_DONE && r_rd_we && spi_data_read_valid) begin
        r_rdata <= spi_data_read;
      end
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter; timeout branch follows SPI_REQ_ARBITER_TIMEOUT_EN.
module tb_spi_req_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_rd_we;
  logic [63:0] req_address;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        spi_enable;
  logic        spi_rd_we;
  logic [31:0] spi_address;
  logic [31:0] spi_data;
  logic        spi_busy;
  logic [31:0] spi_data_read;
  logic        spi_data_read_valid;

  int n_checks = 0;
  int n_errors = 0;

  spi_req_arbiter #(
    .NUM_REQ        (2),
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_rd_we           (req_rd_we),
    .req_address         (req_address),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_error           (rsp_error),
    .spi_enable          (spi_enable),
    .spi_rd_we           (spi_rd_we),
    .spi_address         (spi_address),
    .spi_data            (spi_data),
    .spi_busy            (spi_busy),
    .spi_data_read       (spi_data_read),
    .spi_data_read_valid (spi_data_read_valid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  64'(req_ready),   64'h0);
    check({tag, "_rspv"},   64'(rsp_valid),   64'h0);
    check({tag, "_rspd"},   64'(rsp_data),    64'h0);
    check({tag, "_rspe"},   64'(rsp_error),   64'h0);
    check({tag, "_en"},     64'(spi_enable),  64'h0);
    check({tag, "_rdwe"},   64'(spi_rd_we),   64'h0);
    check({tag, "_addr"},   64'(spi_address), 64'h0);
    check({tag, "_data"},   64'(spi_data),    64'h0);
  endtask

  // One full transaction starting in IDLE, ending back in IDLE.
  task automatic do_txn(input string tag, input logic [1:0] valid, input logic [1:0] rdwe,
                        input logic [63:0] addrs, input logic [63:0] datas,
                        input int busy_len, input logic drv_rd, input logic [31:0] rd_val,
                        input logic stray, input logic hold,
                        input int exp_idx, input logic [31:0] exp_data);
    logic [31:0] e_addr;
    logic [31:0] e_data;
    e_addr = addrs[exp_idx*32 +: 32];
    e_data = datas[exp_idx*32 +: 32];
    req_valid   = valid;
    req_rd_we   = rdwe;
    req_address = addrs;
    req_data    = datas;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(2'b01 << exp_idx));
    step();
    if (!hold) req_valid = 2'b00;
    #1;
    check({tag, "_launch_en"},    64'(spi_enable),  64'h1);
    check({tag, "_launch_addr"},  64'(spi_address), 64'(e_addr));
    check({tag, "_launch_data"},  64'(spi_data),    64'(e_data));
    check({tag, "_launch_rdwe"},  64'(spi_rd_we),   64'(rdwe[exp_idx]));
    check({tag, "_launch_ready"}, 64'(req_ready),   64'h0);
    if (stray) begin
      spi_data_read       = 32'hDEADBEEF;
      spi_data_read_valid = 1'b1;
    end
    step();
    check({tag, "_wb_en"}, 64'(spi_enable), 64'h0);
    spi_busy = 1'b1;
    step();
    spi_data_read_valid = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      if (i == 0 && drv_rd) begin
        spi_data_read       = rd_val;
        spi_data_read_valid = 1'b1;
      end
      step();
      spi_data_read_valid = 1'b0;
      spi_data_read       = 32'h0;
    end
    spi_busy = 1'b0;
    step();
    check({tag, "_rsp_valid"}, 64'(rsp_valid),   64'(2'b01 << exp_idx));
    check({tag, "_rsp_data"},  64'(rsp_data),    64'(exp_data));
    check({tag, "_rsp_error"}, 64'(rsp_error),   64'h0);
    check({tag, "_hold_addr"}, 64'(spi_address), 64'(e_addr));
    step();
    check({tag, "_rsp_clear"}, 64'(rsp_valid),   64'h0);
  endtask

  initial begin
    int n;
    reset               = 1'b1;
    req_valid           = 2'b00;
    req_rd_we           = 2'b00;
    req_address         = 64'h0;
    req_data            = 64'h0;
    spi_busy            = 1'b0;
    spi_data_read       = 32'h0;
    spi_data_read_valid = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    do_txn("wr0", 2'b01, 2'b00, {32'h0, 32'h10}, {32'h0, 32'hA5A5A5A5},
           2, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
    do_txn("rd1", 2'b10, 2'b10, {32'h20, 32'h0}, 64'h0,
           1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1, 32'h12345678);
    do_txn("rd1_stale", 2'b10, 2'b10, {32'h24, 32'h0}, 64'h0,
           2, 1'b0, 32'h0, 1'b1, 1'b0, 1, 32'h12345678);

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      do_txn($sformatf("cont%0d", t), 2'b11, 2'b00, {32'h200, 32'h100},
             {32'hBBBB0001, 32'hAAAA0000}, 1, 1'b0, 32'h0, 1'b0, 1'b1, t % 2, 32'h0);
    end
    req_valid = 2'b00;

    req_valid   = 2'b01;
    req_rd_we   = 2'b01;
    req_address = {32'h0, 32'h44};
    step();
    req_valid = 2'b00;
    step();
    spi_busy = 1'b1;
    step();
    reset = 1'b1;
    step();
    spi_busy = 1'b0;
    check_idle_outputs("midrst");
    reset = 1'b0;
    do_txn("post_rst", 2'b11, 2'b11, {32'h300, 32'h30}, 64'h0,
           1, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 0, 32'h0BADF00D);

    req_valid   = 2'b01;
    req_rd_we   = 2'b01;
    req_address = {32'h0, 32'h50};
    step();
    req_valid = 2'b00;
    step();
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      step();
      n++;
    end
`ifdef SPI_REQ_ARBITER_TIMEOUT_EN
    check("tmo_cycles", 64'(n),         64'd16);
    check("tmo_valid",  64'(rsp_valid), 64'h1);
    check("tmo_error",  64'(rsp_error), 64'h1);
    check("tmo_data",   64'(rsp_data),  64'h0);
    step();
    check("tmo_clear",  64'(rsp_valid), 64'h0);
`else
    check("no_tmo_cycles", 64'(n),         64'd40);
    check("no_tmo_valid",  64'(rsp_valid), 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NUM_REQ, 2, number of requesters.
- DATA_WIDTH, 32, SPI data width.
- ADDRESS_WIDTH, 32, SPI address width.
- TIMEOUT_CYCLES, 4096, watchdog limit.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  in  1  single clock; one clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_rd_we  in  NUM_REQ  per-requester 1=read, 0=write.
- req_address  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i at slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot accept.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_error  out  1  timeout flag, valid with rsp_valid.
- spi_enable  out  1  start pulse to SPI master.
- spi_rd_we  out  1  direction to SPI master.
- spi_address  out  ADDRESS_WIDTH  address to SPI master.
- spi_data  out  DATA_WIDTH  write data to SPI master.
- spi_busy  in  1  SPI master busy.
- spi_data_read  in  DATA_WIDTH  SPI master read data.
- spi_data_read_valid  in  1  SPI master read data strobe.

Function
REQ-003 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND.
REQ-004 IDLE: any req_valid -> round-robin winner gets req_ready=1 same cycle (combinational from req_valid and pointer); accept = req_valid&req_ready; latch rd_we/address/data of winner; -> LAUNCH.
REQ-005 Round-robin: search starts at pointer; after accept pointer = winner+1, wrapping NUM_REQ-1 -> 0.
REQ-006 req_ready SHALL be 0 in every state except IDLE; at most one bit set.
REQ-007 LAUNCH: spi_enable=1 for exactly one cycle; spi_rd_we/address/data SHALL hold latched values from LAUNCH until RESPOND exit; -> WAIT_BUSY.
REQ-008 WAIT_BUSY: spi_busy=1 -> WAIT_DONE.
REQ-009 WAIT_DONE: spi_data_read_valid=1 on a read captures spi_data_read; spi_busy=0 -> RESPOND.
REQ-010 Read finishing with no data_read_valid SHALL return last captured value; rsp_error=0.
REQ-011 RESPOND: rsp_valid[granted]=1 for one cycle with rsp_data (0 for writes) and rsp_error; -> IDLE.
REQ-012 Minimum request-to-response latency = 3 cycles + SPI busy duration; next accept no earlier than cycle after RESPOND.
REQ-013 Requester dropping req_valid before accept SHALL NOT be served; req_valid changes after accept are ignored.
REQ-014 spi_data_read_valid outside WAIT_DONE SHALL be ignored.

Reset
REQ-015 reset SHALL force state IDLE, pointer 0, all outputs 0, latched fields 0, next clock edge.
REQ-016 reset mid-transaction SHALL abandon it without rsp_valid; SPI master is reset separately by its own reset.

Configuration
REQ-017 Macro SPI_REQ_ARBITER_TIMEOUT_EN defined: cycle counter runs in WAIT_BUSY and WAIT_DONE and clears in LAUNCH; reaching TIMEOUT_CYCLES -> RESPOND with rsp_error=1 and rsp_data=0.
REQ-018 Macro undefined: no counter logic; rsp_error tied 0; WAIT states wait indefinitely.

Structure
REQ-019 Package spi_arb_pkg SHALL hold the state enum and default width constants.
REQ-020 Sub-module spi_rr_arbiter (request vector + pointer -> one-hot grant) SHALL be instantiated once.

Verification
REQ-021 Single write: req_valid[0], addr 0x10, data 0xA5A5A5A5 -> one spi_enable pulse with those values; rsp_valid[0] after busy falls; rsp_error=0.
REQ-022 Single read: req_valid[1], rd_we=1, model drives data_read 0x12345678 with valid -> rsp_valid[1], rsp_data=0x12345678.
REQ-023 Contention: req_valid=2'b11 held for 4 transactions from reset -> grants 0,1,0,1.
REQ-024 Timeout (macro defined, TIMEOUT_CYCLES=16): busy never rises -> rsp_valid and rsp_error=1 at cycle 16 of WAIT_BUSY; macro undefined: no response.
REQ-025 Reset asserted in WAIT_DONE -> next cycle all outputs 0, no rsp_valid, and next request is granted from requester 0.
